bus_command_master: RTL and testbench
=====================================

Name: bus_command_master

Overview:
- Initiator side of the shared peripheral register bus: select/rw/register_addr/databus/reg_size.
- Accepts command packets as a byte stream from the host link receiver.
- Performs one read or write transaction on the addressed peripheral and emits reply bytes to the link transmitter.
- Sits between the UART framing logic and all bus peripherals, including global control.

Parameters:
NUM_PERIPH, 8, number of peripherals (one select line each)
SELECT_HOLD, 3, cycles select is held high before sampling reg_size/databus (min 3)
RX_TIMEOUT, 12000, inter-byte timeout in clk_12MHz cycles (1 ms); aborts partial packet

Ports:
clk_12MHz  in  1  system clock
reset  in  1  asynchronous, active-high
rx_data  in  8  received command byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  reply byte
tx_valid  out  1  reply byte valid; held until tx_ready
tx_ready  in  1  transmitter accepts tx_data when high with tx_valid
register_addr  out  8  bus register address
rw  out  1  0 = write, 1 = read
select  out  NUM_PERIPH  one-hot peripheral select; rising edge triggers peripheral
databus  inout  32  driven by master only when rw=0 in SETUP/STROBE, else Z
reg_size  in  3  register size in bytes from selected peripheral (tri-state bus)
busy  out  1  high in any state other than IDLE
cmd_error  out  1  one-cycle pulse on any protocol error

Behaviour:
- Reset (async): state IDLE; select=0, rw=1, register_addr=0, databus=Z, tx_valid=0, tx_data=0, busy=0, cmd_error=0. Reset mid-transaction drops select immediately; no reply is sent.
- Packet byte0: bit7 = rw (1 read), bits6:0 = peripheral index. Byte1: register_addr. Reads end here. Writes add byte2 = length L (1..4), then L data bytes, LSB first. Unsent upper bytes are zero.
- States: IDLE -> GET_REG -> (read) SETUP | (write) GET_LEN -> GET_DATA -> SETUP -> STROBE -> CAPTURE -> SEND_SIZE -> (read and size>0) SEND_DATA -> GAP -> IDLE.
- Timeout: counter clears on each rx_valid. In GET_REG/GET_LEN/GET_DATA, reaching RX_TIMEOUT gives cmd_error pulse, IDLE, no reply.
- SETUP (1 cycle):
  - register_addr and rw are valid.
  - For a write, databus is driven with the assembled word.
  - select stays 0, so addr and data settle one cycle before the select edge.
- STROBE (SELECT_HOLD cycles): select[index]=1, all other bits 0; addr, rw and databus stay stable.
- CAPTURE (1 cycle, select still high):
  - Latch reg_size; values >4 are clamped to 4.
  - For a read, also latch databus.
  - Then drop select and release databus.
- SEND_SIZE: tx_data = latched size, tx_valid=1 until handshake (tx_valid & tx_ready). Writes also reply with this byte, which serves as the ack.
- SEND_DATA: send size bytes, LSB first, one per handshake. tx_data is constant while tx_valid is high and tx_ready is low.
- GAP: 1 cycle with select=0, which guarantees a fresh rising edge for back-to-back commands.
- Unknown register: peripheral returns size 0; reply is the single byte 0x00; no cmd_error.
- Index >= NUM_PERIPH:
  - Remaining packet bytes are still consumed.
  - No select asserted; reply 0x00; cmd_error pulse.
- Write L=0 or L>4: cmd_error pulse, IDLE, no reply. Subsequent bytes parse as a new packet.
- rx_valid outside IDLE/GET_* states: byte dropped, cmd_error pulse, no state change.
- rx_valid on the same cycle a timeout fires: timeout wins; the byte is dropped.

Decomposition:
- Shared package:
  - state encoding
  - packet field constants: RW_BIT=7, INDEX_MSB=6, MAX_LEN=4
  - bus size constant: BUS_BYTES=4
- Sub-module reply_serializer: takes a 32-bit word and a size, emits bytes LSB first via valid/ready, and reports done. It is reusable by other link responders.

Test Plan:
- Read: bytes 0x80, 0x02; peripheral 0 model returns size 4, data 0x0000_1234 -> select[0] high exactly SELECT_HOLD+1 cycles, rw=1; replies 0x04, 0x34, 0x12, 0x00, 0x00.
- Write: 0x00, 0x00, 0x01, 0x02 -> register_addr=0 and databus=0x0000_0002 one cycle before the select[0] rise and stable while high; reply 0x01; model force_pause=1.
- Errors: 0x85, 0x10 (index 5, NUM_PERIPH=4) -> no select, reply 0x00, cmd_error pulse. Write with L=5 -> cmd_error, no reply.
- Timeout and flow control:
  - 0x80 then silence for 12000 cycles -> cmd_error, IDLE, busy=0.
  - Read with tx_ready held low 50 cycles -> tx_data and tx_valid stable, no byte lost.
- Back-to-back and reset: two reads sent consecutively -> select low >=1 cycle between them, two full replies. Assert reset mid-STROBE -> select=0 and databus=Z in the same cycle, no reply.

Source files
------------

// File: rtl/bus_command_master_pkg.sv
// Shared definitions for the bus command master and its reply path.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - command packet field positions and limits
//   - bus width in bytes and a size clamp helper
package bus_command_master_pkg;

  // Command packet fields
  localparam int unsigned RW_BIT    = 7;
  localparam int unsigned INDEX_MSB = 6;
  localparam int unsigned MAX_LEN   = 4;

  // Peripheral data bus width in bytes
  localparam int unsigned BUS_BYTES = 4;

  // FSM encoding
  localparam int unsigned StateW = 4;
  localparam logic [StateW-1:0] StIdle     = 4'd0;
  localparam logic [StateW-1:0] StGetReg   = 4'd1;
  localparam logic [StateW-1:0] StGetLen   = 4'd2;
  localparam logic [StateW-1:0] StGetData  = 4'd3;
  localparam logic [StateW-1:0] StSetup    = 4'd4;
  localparam logic [StateW-1:0] StStrobe   = 4'd5;
  localparam logic [StateW-1:0] StCapture  = 4'd6;
  localparam logic [StateW-1:0] StSendSize = 4'd7;
  localparam logic [StateW-1:0] StSendData = 4'd8;
  localparam logic [StateW-1:0] StGap      = 4'd9;

  // Peripherals may report sizes up to 7; the bus only carries BUS_BYTES.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    if (size > 3'(BUS_BYTES)) begin
      return 3'(BUS_BYTES);
    end
    return size;
  endfunction

endpackage

// File: rtl/bus_command_master_reply_serializer.sv
// Reply serializer: emits the low size_i bytes of a word, LSB first, over a
// valid/ready byte link. Reusable by any link responder.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             load word_i/size_i (one-cycle strobe)
//   word_i, size_i      word to send and number of bytes (clamped to bus width)
//   tx_data_o/valid_o   byte stream out; data held while valid and not ready
//   tx_ready_i          sink accepts the byte
//   done_o              pulses on the handshake of the last byte
module bus_command_master_reply_serializer
  import bus_command_master_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [8*BUS_BYTES-1:0] word_i,
  input  logic [2:0]             size_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   done_o
);

  logic [8*BUS_BYTES-1:0] word_q, word_d;
  logic [2:0]             left_q, left_d;
  logic                   handshake;

  assign tx_valid_o = (left_q != 3'd0);
  assign tx_data_o  = word_q[7:0];
  assign handshake  = tx_valid_o && tx_ready_i;
  // An empty request completes immediately.
  assign done_o     = (handshake && (left_q == 3'd1)) || (start_i && (size_i == 3'd0));

  always_comb begin
    word_d = word_q;
    left_d = left_q;
    if (start_i) begin
      word_d = word_i;
      left_d = clamp_size(size_i);
    end else if (handshake) begin
      word_d = word_q >> 8;
      left_d = left_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      left_q <= 3'd0;
    end else begin
      word_q <= word_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/bus_command_master.sv
// Bus command master: parses command packets from the host link, runs one
// read or write on the shared peripheral register bus and returns reply bytes.
// Ports:
//   clk_12mhz_i, reset_i      clock, asynchronous active-high reset
//   rx_data_i, rx_valid_i     received command byte stream
//   tx_data_o, tx_valid_o,    reply byte stream (held until tx_ready_i)
//   tx_ready_i
//   register_addr_o, rw_o     bus address and direction (1 = read)
//   select_o                  one-hot peripheral select; rising edge triggers
//   databus_io                shared data bus, driven only for writes
//   reg_size_i                size reported by the selected peripheral
//   busy_o                    not idle
//   cmd_error_o               one-cycle pulse on any protocol error
module bus_command_master
  import bus_command_master_pkg::*;
#(
  parameter int unsigned NUM_PERIPH  = 8,
  parameter int unsigned SELECT_HOLD = 3,
  parameter int unsigned RX_TIMEOUT  = 12000
) (
  input  logic                   clk_12mhz_i,
  input  logic                   reset_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [7:0]             register_addr_o,
  output logic                   rw_o,
  output logic [NUM_PERIPH-1:0]  select_o,
  inout  wire  [8*BUS_BYTES-1:0] databus_io,
  input  logic [2:0]             reg_size_i,
  output logic                   busy_o,
  output logic                   cmd_error_o
);

  localparam int unsigned IdxW   = INDEX_MSB + 1;
  localparam int unsigned TimerW = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned HoldW  = $clog2(SELECT_HOLD + 1);

  localparam logic [IdxW-1:0]   NumPeriphIdx = IdxW'(NUM_PERIPH);
  localparam logic [TimerW-1:0] TimeoutLast  = TimerW'(RX_TIMEOUT - 1);
  localparam logic [HoldW-1:0]  HoldLast     = HoldW'(SELECT_HOLD - 1);
  localparam logic [7:0]        MaxLenByte   = 8'(MAX_LEN);

  logic [StateW-1:0]      state_q, state_d;
  logic                   rw_q, rw_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [7:0]             addr_q, addr_d;
  logic [2:0]             len_q, len_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [8*BUS_BYTES-1:0] wdata_q, wdata_d;
  logic [8*BUS_BYTES-1:0] rdata_q, rdata_d;
  logic [2:0]             size_q, size_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   err_q, err_d;

  logic       in_get, rx_state, timeout, idx_ok;
  logic       bus_phase, sel_phase;
  logic       ser_start, ser_done, ser_valid;
  logic [7:0] ser_data;

  assign in_get    = (state_q == StGetReg) || (state_q == StGetLen) || (state_q == StGetData);
  assign rx_state  = in_get || (state_q == StIdle);
  assign timeout   = in_get && (timer_q == TimeoutLast);
  assign idx_ok    = (idx_q < NumPeriphIdx);
  assign bus_phase = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StCapture);
  assign sel_phase = (state_q == StStrobe) || (state_q == StCapture);

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    size_d    = size_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    err_d     = 1'b0;
    ser_start = 1'b0;

    // Inter-byte timer only runs while a packet is partially received.
    if (!in_get || rx_valid_i) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // Stray bytes while the bus or reply is active are dropped, FSM keeps going.
    if (rx_valid_i && !rx_state) begin
      err_d = 1'b1;
    end

    if (timeout) begin
      // Timeout wins over a byte arriving in the same cycle.
      err_d   = 1'b1;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            rw_d    = rx_data_i[RW_BIT];
            idx_d   = rx_data_i[INDEX_MSB:0];
            state_d = StGetReg;
            if (rx_data_i[INDEX_MSB:0] >= NumPeriphIdx) begin
              err_d = 1'b1;
            end
          end
        end
        StGetReg: begin
          if (rx_valid_i) begin
            addr_d  = rx_data_i;
            state_d = rw_q ? StSetup : StGetLen;
          end
        end
        StGetLen: begin
          if (rx_valid_i) begin
            if ((rx_data_i == 8'd0) || (rx_data_i > MaxLenByte)) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              len_d   = rx_data_i[2:0];
              cnt_d   = 2'd0;
              wdata_d = '0;
              state_d = StGetData;
            end
          end
        end
        StGetData: begin
          if (rx_valid_i) begin
            wdata_d[8*cnt_q +: 8] = rx_data_i;
            cnt_d = cnt_q + 1'b1;
            if (({1'b0, cnt_q} + 3'd1) == len_q) begin
              state_d = StSetup;
            end
          end
        end
        StSetup: begin
          hold_d  = '0;
          state_d = StStrobe;
        end
        StStrobe: begin
          if (hold_q == HoldLast) begin
            state_d = StCapture;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StCapture: begin
          // Nothing answers an out-of-range index, so report size 0.
          size_d = idx_ok ? clamp_size(reg_size_i) : 3'd0;
          if (rw_q) begin
            rdata_d = idx_ok ? databus_io : '0;
          end
          state_d = StSendSize;
        end
        StSendSize: begin
          if (tx_ready_i) begin
            if (rw_q && (size_q != 3'd0)) begin
              ser_start = 1'b1;
              state_d   = StSendData;
            end else begin
              state_d = StGap;
            end
          end
        end
        StSendData: begin
          if (ser_done) begin
            state_d = StGap;
          end
        end
        StGap: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_12mhz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rw_q    <= 1'b1;
      idx_q   <= '0;
      addr_q  <= 8'd0;
      len_q   <= 3'd0;
      cnt_q   <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= 3'd0;
      hold_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  bus_command_master_reply_serializer u_reply_serializer (
    .clk_i      (clk_12mhz_i),
    .rst_i      (reset_i),
    .start_i    (ser_start),
    .word_i     (rdata_q),
    .size_i     (size_q),
    .tx_data_o  (ser_data),
    .tx_valid_o (ser_valid),
    .tx_ready_i (tx_ready_i && (state_q == StSendData)),
    .done_o     (ser_done)
  );

  // Select is decoded from state so an async reset drops it immediately.
  always_comb begin
    select_o = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      select_o[i] = sel_phase && idx_ok && (idx_q == IdxW'(i));
    end
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'd0;
    if (state_q == StSendSize) begin
      tx_valid_o = 1'b1;
      tx_data_o  = {5'd0, size_q};
    end else if (state_q == StSendData) begin
      tx_valid_o = ser_valid;
      tx_data_o  = ser_data;
    end
  end

  // Write data is driven from SETUP through CAPTURE so it is stable for the
  // whole time select is high.
  assign databus_io      = (bus_phase && !rw_q && idx_ok) ? wdata_q : 'z;
  assign register_addr_o = addr_q;
  assign rw_o            = rw_q;
  assign busy_o          = (state_q != StIdle);
  assign cmd_error_o     = err_q;

endmodule

// File: tb/tb_bus_command_master.sv
module tb_bus_command_master;

  localparam int NP   = 4;
  localparam int HOLD = 3;
  localparam int TO   = 12000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [7:0]    register_addr;
  logic          rw;
  logic [NP-1:0] select;
  wire  [31:0]   databus;
  logic [2:0]    reg_size;
  logic          busy;
  logic          cmd_error;

  always #5 clk = ~clk;

  bus_command_master #(
    .NUM_PERIPH  (NP),
    .SELECT_HOLD (HOLD),
    .RX_TIMEOUT  (TO)
  ) dut (
    .clk_12mhz_i     (clk),
    .reset_i         (reset),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .tx_data_o       (tx_data),
    .tx_valid_o      (tx_valid),
    .tx_ready_i      (tx_ready),
    .register_addr_o (register_addr),
    .rw_o            (rw),
    .select_o        (select),
    .databus_io      (databus),
    .reg_size_i      (reg_size),
    .busy_o          (busy),
    .cmd_error_o     (cmd_error)
  );

  // Peripheral 0: reg 0 = control (1 byte, bit1 force_pause),
  // reg 2 = 0x1234 (4 bytes), reg 3 = 0xA1B2C3D4 reporting size 7, else unknown.
  logic [7:0]  ctrl_reg = 8'd0;
  logic        force_pause;
  logic [2:0]  p_size;
  logic [31:0] p_rdata;

  assign force_pause = ctrl_reg[1];

  always_comb begin
    p_size  = 3'd0;
    p_rdata = 32'd0;
    case (register_addr)
      8'h00: begin p_size = 3'd1; p_rdata = {24'd0, ctrl_reg}; end
      8'h02: begin p_size = 3'd4; p_rdata = 32'h0000_1234; end
      8'h03: begin p_size = 3'd7; p_rdata = 32'hA1B2_C3D4; end
      default: ;
    endcase
  end

  assign reg_size = select[0] ? p_size : 3'd0;
  assign databus  = (select[0] && rw) ? p_rdata : 32'bz;

  always @(posedge select[0]) begin
    if (!rw && register_addr == 8'h00) ctrl_reg = databus[7:0];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected reply bytes queued by stimulus, popped on handshake.
  logic [7:0] exp_q[$];
  int rx_count = 0;

  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_reply: got %0h expected none", tx_data);
      end else begin
        check("reply_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  int err_cnt = 0;
  always @(negedge clk) if (cmd_error) err_cnt++;

  // Select monitor: setup one cycle before the rise, stability while high.
  logic [NP-1:0] sel_prev = '0, sel_hold = '0;
  logic [7:0]    addr_prev = 8'd0, last_addr = 8'd0;
  logic [31:0]   data_prev = 32'd0, last_data = 32'd0;
  logic          rw_prev = 1'b1, last_rw = 1'b1;
  int sel_pulses = 0, cur_len = 0, last_len = 0, low_run = 0, last_gap = 0, stab_err = 0;

  always @(negedge clk) begin
    if (select != '0 && sel_prev == '0) begin
      sel_pulses++;
      cur_len   = 1;
      last_gap  = low_run;
      sel_hold  = select;
      last_addr = register_addr;
      last_rw   = rw;
      last_data = databus;
      if (register_addr != addr_prev || rw != rw_prev || (!rw && databus != data_prev))
        stab_err++;
    end else if (select != '0) begin
      cur_len++;
      if (select != sel_hold || register_addr != last_addr || rw != last_rw ||
          (!rw && databus != last_data))
        stab_err++;
    end else if (sel_prev != '0) begin
      last_len = cur_len;
      low_run  = 1;
    end else begin
      low_run++;
    end
    sel_prev  = select;
    addr_prev = register_addr;
    rw_prev   = rw;
    data_prev = databus;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_reply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_done: got busy=%0d pending=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e0, p0, r0, n;
    logic [7:0] snap_data;
    int unstable;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_select", {28'd0, select}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd1);
    check("rst_addr", {24'd0, register_addr}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Read peripheral 0 register 2
    e0 = err_cnt;
    push_reply(8'h04, 8'h34, 8'h12, 8'h00, 8'h00);
    send_byte(8'h80); send_byte(8'h02);
    wait_done("read");
    check("read_sel_len", last_len, HOLD + 1);
    check("read_rw", {31'd0, last_rw}, 32'd1);
    check("read_addr", {24'd0, last_addr}, 32'h02);
    check("read_no_err", err_cnt, e0);

    // Write control register: force_pause
    exp_q.push_back(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    wait_done("write");
    check("write_data", last_data, 32'h0000_0002);
    check("write_addr", {24'd0, last_addr}, 32'h00);
    check("write_rw", {31'd0, last_rw}, 32'd0);
    check("write_force_pause", {31'd0, force_pause}, 32'd1);

    // Index out of range
    p0 = sel_pulses; e0 = err_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h85); send_byte(8'h10);
    wait_done("bad_index");
    check("bad_index_no_select", sel_pulses, p0);
    check("bad_index_err", err_cnt, e0 + 1);

    // Write with illegal length
    e0 = err_cnt; r0 = rx_count;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    wait_done("bad_len");
    check("bad_len_err", err_cnt, e0 + 1);
    check("bad_len_no_reply", rx_count, r0);
    check("bad_len_idle", {31'd0, busy}, 32'd0);

    // Unknown register
    e0 = err_cnt;
    exp_q.push_back(8'h00);
    send_byte(8'h80); send_byte(8'h55);
    wait_done("unknown_reg");
    check("unknown_reg_no_err", err_cnt, e0);

    // Inter-byte timeout
    e0 = err_cnt; r0 = rx_count;
    send_byte(8'h80);
    n = 0;
    while (!cmd_error && n < 13000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < TO - 10 || n > TO + 10) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d expected about %0d", n, TO);
    end
    @(negedge clk);
    check("timeout_idle", {31'd0, busy}, 32'd0);
    check("timeout_err", err_cnt, e0 + 1);
    check("timeout_no_reply", rx_count, r0);

    // Flow control: hold tx_ready low
    @(posedge clk); #1 tx_ready = 1'b0;
    push_reply(8'h04, 8'h34, 8'h12, 8'h00, 8'h00);
    send_byte(8'h80); send_byte(8'h02);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    snap_data = tx_data;
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data != snap_data) unstable++;
    end
    check("stall_stable", unstable, 0);
    check("stall_size_byte", {24'd0, tx_data}, 32'h04);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done("stall");

    // Back-to-back reads, second one with an oversize reg_size
    push_reply(8'h04, 8'h34, 8'h12, 8'h00, 8'h00);
    push_reply(8'h04, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
    send_byte(8'h80); send_byte(8'h02);
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h80); send_byte(8'h03);
    wait_done("b2b");
    total++;
    if (last_gap < 1) begin
      bad++;
      $display("FAIL b2b_gap: got %0d expected >=1", last_gap);
    end
    check("b2b_addr", {24'd0, last_addr}, 32'h03);
    check("select_stability", stab_err, 0);

    // Reset during STROBE
    r0 = rx_count;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h07);
    n = 0;
    while (select[0] == 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("strobe_reached", {31'd0, select[0]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midreset_select", {28'd0, select}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset_no_reply", rx_count, r0);
    check("midreset_idle", {31'd0, busy}, 32'd0);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
